// File: rtl/rvga_mem_arbiter_pkg.sv
// rtl/rvga_mem_arbiter_pkg.sv - shared types for the L1-to-memory arbiter
package rvga_mem_arbiter_pkg;

  parameter int LINE_BYTES = 16;

  typedef logic [15:0] rvga_bytemask;

  typedef enum logic {
    e_rvga_owner_ic = 1'b0,
    e_rvga_owner_dc = 1'b1
  } rvga_mem_owner_e;

  typedef enum logic [1:0] {
    e_rvga_arb_idle  = 2'd0,
    e_rvga_arb_issue = 2'd1,
    e_rvga_arb_wait  = 2'd2
  } rvga_arb_state_e;

endpackage

// File: rtl/rvga_mem_arbiter_if.sv
// rtl/rvga_mem_arbiter_if.sv - IC, DC and memory port bundle around the arbiter
interface rvga_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  localparam int MASK_W = LINE_W / 8;

  logic              ic_req_v_i;
  logic [ADDR_W-1:0] ic_addr_i;
  logic              ic_req_ready_o;
  logic              ic_resp_v_o;
  logic [LINE_W-1:0] ic_resp_data_o;

  logic              dc_req_v_i;
  logic              dc_we_i;
  logic [ADDR_W-1:0] dc_addr_i;
  logic [LINE_W-1:0] dc_wdata_i;
  logic [MASK_W-1:0] dc_wmask_i;
  logic              dc_req_ready_o;
  logic              dc_resp_v_o;
  logic [LINE_W-1:0] dc_resp_data_o;

  logic              mem_req_v_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic [MASK_W-1:0] mem_wmask_o;
  logic              mem_req_ready_i;
  logic              mem_resp_v_i;
  logic [LINE_W-1:0] mem_resp_data_i;

  // Arbiter side.
  modport slave (
    input  ic_req_v_i, ic_addr_i,
    output ic_req_ready_o, ic_resp_v_o, ic_resp_data_o,
    input  dc_req_v_i, dc_we_i, dc_addr_i, dc_wdata_i, dc_wmask_i,
    output dc_req_ready_o, dc_resp_v_o, dc_resp_data_o,
    output mem_req_v_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_req_ready_i, mem_resp_v_i, mem_resp_data_i
  );

  // Caches and memory side.
  modport master (
    output ic_req_v_i, ic_addr_i,
    input  ic_req_ready_o, ic_resp_v_o, ic_resp_data_o,
    output dc_req_v_i, dc_we_i, dc_addr_i, dc_wdata_i, dc_wmask_i,
    input  dc_req_ready_o, dc_resp_v_o, dc_resp_data_o,
    input  mem_req_v_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_req_ready_i, mem_resp_v_i, mem_resp_data_i
  );

endinterface

// File: rtl/rvga_rr_arb2.sv
// rtl/rvga_rr_arb2.sv - combinational two-way round-robin picker
module rvga_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // On a tie the side that did not win last time gets the grant.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/rvga_mem_arbiter.sv
// rtl/rvga_mem_arbiter.sv - shares one line-wide memory port between IC and DC
module rvga_mem_arbiter
  import rvga_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  rvga_mem_arbiter_if.slave bus
);

  localparam int MASK_W = LINE_W / 8;
  localparam int OFF_W  = $clog2(MASK_W);

  rvga_arb_state_e   state_q;
  rvga_mem_owner_e   owner_q;
  rvga_mem_owner_e   last_grant_q;
  logic              mem_req_v_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic              ic_resp_v_q;
  logic              dc_resp_v_q;
  logic [LINE_W-1:0] ic_resp_data_q;
  logic [LINE_W-1:0] dc_resp_data_q;

  logic [1:0]        gnt;
  logic              idle;

  rvga_rr_arb2 u_rr (
    .req_i  ({bus.dc_req_v_i, bus.ic_req_v_i}),
    .last_i (last_grant_q == e_rvga_owner_dc),
    .gnt_o  (gnt)
  );

  assign idle = (state_q == e_rvga_arb_idle);

  assign bus.ic_req_ready_o = idle & gnt[0];
  assign bus.dc_req_ready_o = idle & gnt[1];

  assign bus.ic_resp_v_o    = ic_resp_v_q;
  assign bus.dc_resp_v_o    = dc_resp_v_q;
  assign bus.ic_resp_data_o = ic_resp_data_q;
  assign bus.dc_resp_data_o = dc_resp_data_q;

  assign bus.mem_req_v_o = mem_req_v_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_wmask_o = wmask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= e_rvga_arb_idle;
      owner_q        <= e_rvga_owner_ic;
      last_grant_q   <= e_rvga_owner_dc;
      mem_req_v_q    <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wmask_q        <= '0;
      ic_resp_v_q    <= 1'b0;
      dc_resp_v_q    <= 1'b0;
      ic_resp_data_q <= '0;
      dc_resp_data_q <= '0;
    end else begin
      ic_resp_v_q <= 1'b0;
      dc_resp_v_q <= 1'b0;
      case (state_q)
        e_rvga_arb_idle: begin
          if (gnt[0]) begin
            owner_q      <= e_rvga_owner_ic;
            last_grant_q <= e_rvga_owner_ic;
            we_q         <= 1'b0;
            addr_q       <= {bus.ic_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            wdata_q      <= '0;
            wmask_q      <= '0;
            mem_req_v_q  <= 1'b1;
            state_q      <= e_rvga_arb_issue;
          end else if (gnt[1]) begin
            owner_q      <= e_rvga_owner_dc;
            last_grant_q <= e_rvga_owner_dc;
            we_q         <= bus.dc_we_i;
            addr_q       <= {bus.dc_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            wdata_q      <= bus.dc_wdata_i;
            wmask_q      <= bus.dc_wmask_i;
            mem_req_v_q  <= 1'b1;
            state_q      <= e_rvga_arb_issue;
          end
        end
        e_rvga_arb_issue: begin
          if (bus.mem_req_ready_i) begin
            mem_req_v_q <= 1'b0;
            state_q     <= e_rvga_arb_wait;
          end
        end
        e_rvga_arb_wait: begin
          if (bus.mem_resp_v_i) begin
            if (owner_q == e_rvga_owner_ic) begin
              ic_resp_v_q    <= 1'b1;
              ic_resp_data_q <= bus.mem_resp_data_i;
            end else begin
              dc_resp_v_q    <= 1'b1;
              // Write acks carry no data back to the DC.
              dc_resp_data_q <= we_q ? '0 : bus.mem_resp_data_i;
            end
            state_q <= e_rvga_arb_idle;
          end
        end
        default: state_q <= e_rvga_arb_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// tb/tb_rvga_mem_arbiter.sv - directed self-checking bench for rvga_mem_arbiter
module tb_rvga_mem_arbiter;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  localparam logic [127:0] D_BEEF = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
  localparam logic [127:0] D_IC2  = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] D_DC2  = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] D_WGRB = 128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D;
  localparam logic [127:0] D_WDAT = 128'h0000FFFF_1234ABCD_FEDC9876_00112233;
  localparam logic [127:0] D_IC3  = 128'h99990000_88881111_77772222_66663333;
  localparam logic [127:0] D_LATE = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
  localparam logic [127:0] D_IC4  = 128'h0C0C0C0C_1D1D1D1D_2E2E2E2E_3F3F3F3F;

  rvga_mem_arbiter_if #(.ADDR_W(32), .LINE_W(128)) bus ();

  rvga_mem_arbiter #(.ADDR_W(32), .LINE_W(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.ic_req_v_i      = 1'b0;
    bus.ic_addr_i       = '0;
    bus.dc_req_v_i      = 1'b0;
    bus.dc_we_i         = 1'b0;
    bus.dc_addr_i       = '0;
    bus.dc_wdata_i      = '0;
    bus.dc_wmask_i      = '0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_resp_v_i    = 1'b0;
    bus.mem_resp_data_i = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.ic_req_ready_o !== 1'b0) begin errors++; $display("FAIL reset ic_req_ready: got %b expected 0", bus.ic_req_ready_o); end
    checks++; if (bus.dc_req_ready_o !== 1'b0) begin errors++; $display("FAIL reset dc_req_ready: got %b expected 0", bus.dc_req_ready_o); end
    checks++; if (bus.ic_resp_v_o !== 1'b0) begin errors++; $display("FAIL reset ic_resp_v: got %b expected 0", bus.ic_resp_v_o); end
    checks++; if (bus.dc_resp_v_o !== 1'b0) begin errors++; $display("FAIL reset dc_resp_v: got %b expected 0", bus.dc_resp_v_o); end
    checks++; if (bus.mem_req_v_o !== 1'b0) begin errors++; $display("FAIL reset mem_req_v: got %b expected 0", bus.mem_req_v_o); end
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL reset mem_we: got %b expected 0", bus.mem_we_o); end
    checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset mem_addr: got %h expected 0", bus.mem_addr_o); end
    checks++; if (bus.mem_wdata_o !== 128'h0) begin errors++; $display("FAIL reset mem_wdata: got %h expected 0", bus.mem_wdata_o); end
    checks++; if (bus.mem_wmask_o !== 16'h0) begin errors++; $display("FAIL reset mem_wmask: got %h expected 0", bus.mem_wmask_o); end
    checks++; if (bus.ic_resp_data_o !== 128'h0) begin errors++; $display("FAIL reset ic_resp_data: got %h expected 0", bus.ic_resp_data_o); end
    checks++; if (bus.dc_resp_data_o !== 128'h0) begin errors++; $display("FAIL reset dc_resp_data: got %h expected 0", bus.dc_resp_data_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ic_read();
    @(negedge clk);
    bus.ic_req_v_i = 1'b1;
    bus.ic_addr_i  = 32'h0000_1234;
    #1;
    checks++; if (bus.ic_req_ready_o !== 1'b1) begin errors++; $display("FAIL icread ic_ready: got %b expected 1", bus.ic_req_ready_o); end
    checks++; if (bus.dc_req_ready_o !== 1'b0) begin errors++; $display("FAIL icread dc_ready: got %b expected 0", bus.dc_req_ready_o); end
    @(negedge clk);
    bus.ic_req_v_i      = 1'b0;
    bus.ic_addr_i       = 32'hFFFF_FFFF;
    bus.mem_req_ready_i = 1'b1;
    #1;
    checks++; if (bus.mem_req_v_o !== 1'b1) begin errors++; $display("FAIL icread mem_req_v: got %b expected 1", bus.mem_req_v_o); end
    checks++; if (bus.mem_addr_o !== 32'h0000_1230) begin errors++; $display("FAIL icread mem_addr: got %h expected 00001230", bus.mem_addr_o); end
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL icread mem_we: got %b expected 0", bus.mem_we_o); end
    checks++; if (bus.mem_wmask_o !== 16'h0) begin errors++; $display("FAIL icread mem_wmask: got %h expected 0", bus.mem_wmask_o); end
    @(negedge clk);
    bus.mem_req_ready_i = 1'b0;
    bus.mem_resp_v_i    = 1'b1;
    bus.mem_resp_data_i = D_BEEF;
    #1;
    checks++; if (bus.ic_resp_v_o !== 1'b0) begin errors++; $display("FAIL icread early resp_v: got %b expected 0", bus.ic_resp_v_o); end
    checks++; if (bus.mem_req_v_o !== 1'b0) begin errors++; $display("FAIL icread mem_req_v in wait: got %b expected 0", bus.mem_req_v_o); end
    @(negedge clk);
    bus.mem_resp_v_i    = 1'b0;
    bus.mem_resp_data_i = '0;
    #1;
    checks++; if (bus.ic_resp_v_o !== 1'b1) begin errors++; $display("FAIL icread ic_resp_v: got %b expected 1", bus.ic_resp_v_o); end
    checks++; if (bus.ic_resp_data_o !== D_BEEF) begin errors++; $display("FAIL icread ic_resp_data: got %h expected %h", bus.ic_resp_data_o, D_BEEF); end
    checks++; if (bus.dc_resp_v_o !== 1'b0) begin errors++; $display("FAIL icread dc_resp_v: got %b expected 0", bus.dc_resp_v_o); end
    @(negedge clk);
    #1;
    checks++; if (bus.ic_resp_v_o !== 1'b0) begin errors++; $display("FAIL icread resp_v pulse width: got %b expected 0", bus.ic_resp_v_o); end
    checks++; if (bus.ic_resp_data_o !== D_BEEF) begin errors++; $display("FAIL icread data hold: got %h expected %h", bus.ic_resp_data_o, D_BEEF); end
  endtask

  task automatic test_back_to_back();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.ic_req_v_i = 1'b1;
    bus.ic_addr_i  = 32'h0000_0100;
    bus.dc_req_v_i = 1'b1;
    bus.dc_we_i    = 1'b0;
    bus.dc_addr_i  = 32'h0000_0200;
    #1;
    checks++; if (bus.ic_req_ready_o !== 1'b1) begin errors++; $display("FAIL tie ic_ready: got %b expected 1", bus.ic_req_ready_o); end
    checks++; if (bus.dc_req_ready_o !== 1'b0) begin errors++; $display("FAIL tie dc_ready: got %b expected 0", bus.dc_req_ready_o); end
    @(negedge clk);
    bus.ic_req_v_i      = 1'b0;
    bus.mem_req_ready_i = 1'b1;
    #1;
    checks++; if (bus.mem_addr_o !== 32'h0000_0100) begin errors++; $display("FAIL tie ic mem_addr: got %h expected 00000100", bus.mem_addr_o); end
    checks++; if (bus.dc_req_ready_o !== 1'b0) begin errors++; $display("FAIL tie dc_ready in issue: got %b expected 0", bus.dc_req_ready_o); end
    @(negedge clk);
    bus.mem_req_ready_i = 1'b0;
    bus.mem_resp_v_i    = 1'b1;
    bus.mem_resp_data_i = D_IC2;
    #1;
    checks++; if (bus.dc_req_ready_o !== 1'b0) begin errors++; $display("FAIL tie dc_ready in wait: got %b expected 0", bus.dc_req_ready_o); end
    @(negedge clk);
    bus.mem_resp_v_i    = 1'b0;
    #1;
    checks++; if (bus.ic_resp_v_o !== 1'b1) begin errors++; $display("FAIL b2b ic_resp_v: got %b expected 1", bus.ic_resp_v_o); end
    checks++; if (bus.dc_req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b dc_ready with resp: got %b expected 1", bus.dc_req_ready_o); end
    @(negedge clk);
    bus.dc_req_v_i      = 1'b0;
    bus.mem_req_ready_i = 1'b1;
    #1;
    checks++; if (bus.mem_req_v_o !== 1'b1) begin errors++; $display("FAIL b2b dc mem_req_v: got %b expected 1", bus.mem_req_v_o); end
    checks++; if (bus.mem_addr_o !== 32'h0000_0200) begin errors++; $display("FAIL b2b dc mem_addr: got %h expected 00000200", bus.mem_addr_o); end
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL b2b dc mem_we: got %b expected 0", bus.mem_we_o); end
    @(negedge clk);
    bus.mem_req_ready_i = 1'b0;
    bus.mem_resp_v_i    = 1'b1;
    bus.mem_resp_data_i = D_DC2;
    @(negedge clk);
    bus.mem_resp_v_i    = 1'b0;
    #1;
    checks++; if (bus.dc_resp_v_o !== 1'b1) begin errors++; $display("FAIL b2b dc_resp_v: got %b expected 1", bus.dc_resp_v_o); end
    checks++; if (bus.dc_resp_data_o !== D_DC2) begin errors++; $display("FAIL b2b dc_resp_data: got %h expected %h", bus.dc_resp_data_o, D_DC2); end
    checks++; if (bus.ic_resp_v_o !== 1'b0) begin errors++; $display("FAIL b2b ic_resp_v: got %b expected 0", bus.ic_resp_v_o); end
  endtask

  task automatic test_dc_write_backpressure();
    @(negedge clk);
    bus.dc_req_v_i = 1'b1;
    bus.dc_we_i    = 1'b1;
    bus.dc_addr_i  = 32'h0000_0040;
    bus.dc_wmask_i = 16'h00F0;
    bus.dc_wdata_i = D_WDAT;
    #1;
    checks++; if (bus.dc_req_ready_o !== 1'b1) begin errors++; $display("FAIL wr dc_ready: got %b expected 1", bus.dc_req_ready_o); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.dc_req_v_i = 1'b0;
        bus.dc_we_i    = 1'b0;
        bus.dc_addr_i  = 32'hFFFF_FFF0;
        bus.dc_wmask_i = 16'hFFFF;
        bus.dc_wdata_i = D_WGRB;
      end
      bus.mem_req_ready_i = (i == 5);
      #1;
      checks++; if (bus.mem_req_v_o !== 1'b1) begin errors++; $display("FAIL wr issue%0d mem_req_v: got %b expected 1", i, bus.mem_req_v_o); end
      checks++; if (bus.mem_we_o !== 1'b1) begin errors++; $display("FAIL wr issue%0d mem_we: got %b expected 1", i, bus.mem_we_o); end
      checks++; if (bus.mem_addr_o !== 32'h0000_0040) begin errors++; $display("FAIL wr issue%0d mem_addr: got %h expected 00000040", i, bus.mem_addr_o); end
      checks++; if (bus.mem_wmask_o !== 16'h00F0) begin errors++; $display("FAIL wr issue%0d mem_wmask: got %h expected 00f0", i, bus.mem_wmask_o); end
      checks++; if (bus.mem_wdata_o !== D_WDAT) begin errors++; $display("FAIL wr issue%0d mem_wdata: got %h expected %h", i, bus.mem_wdata_o, D_WDAT); end
    end
    @(negedge clk);
    bus.mem_req_ready_i = 1'b0;
    bus.mem_resp_v_i    = 1'b1;
    bus.mem_resp_data_i = D_WGRB;
    #1;
    checks++; if (bus.dc_resp_v_o !== 1'b0) begin errors++; $display("FAIL wr early dc_resp_v: got %b expected 0", bus.dc_resp_v_o); end
    @(negedge clk);
    bus.mem_resp_v_i    = 1'b0;
    bus.mem_resp_data_i = '0;
    #1;
    checks++; if (bus.dc_resp_v_o !== 1'b1) begin errors++; $display("FAIL wr dc_resp_v: got %b expected 1", bus.dc_resp_v_o); end
    checks++; if (bus.dc_resp_data_o !== 128'h0) begin errors++; $display("FAIL wr ack data: got %h expected 0", bus.dc_resp_data_o); end
  endtask

  task automatic test_contention();
    logic exp_ic;
    @(negedge clk);
    bus.ic_req_v_i = 1'b1;
    bus.ic_addr_i  = 32'h0000_0300;
    bus.dc_req_v_i = 1'b1;
    bus.dc_we_i    = 1'b0;
    bus.dc_addr_i  = 32'h0000_0400;
    for (int t = 0; t < 6; t++) begin
      exp_ic = ((t % 2) == 0);
      #1;
      checks++; if (bus.ic_req_ready_o !== exp_ic) begin errors++; $display("FAIL rr%0d ic_ready: got %b expected %b", t, bus.ic_req_ready_o, exp_ic); end
      checks++; if (bus.dc_req_ready_o !== !exp_ic) begin errors++; $display("FAIL rr%0d dc_ready: got %b expected %b", t, bus.dc_req_ready_o, !exp_ic); end
      @(negedge clk);
      bus.mem_req_ready_i = 1'b1;
      #1;
      checks++; if (bus.mem_addr_o !== (exp_ic ? 32'h300 : 32'h400)) begin errors++; $display("FAIL rr%0d mem_addr: got %h expected %h", t, bus.mem_addr_o, exp_ic ? 32'h300 : 32'h400); end
      @(negedge clk);
      bus.mem_req_ready_i = 1'b0;
      bus.mem_resp_v_i    = 1'b1;
      bus.mem_resp_data_i = 128'(t + 1);
      @(negedge clk);
      bus.mem_resp_v_i    = 1'b0;
      #1;
      checks++; if ({bus.ic_resp_v_o, bus.dc_resp_v_o} !== {exp_ic, !exp_ic}) begin errors++; $display("FAIL rr%0d resp_v ic/dc: got %b%b expected %b%b", t, bus.ic_resp_v_o, bus.dc_resp_v_o, exp_ic, !exp_ic); end
    end
    bus.ic_req_v_i = 1'b0;
    bus.dc_req_v_i = 1'b0;
  endtask

  task automatic test_stray_response();
    @(negedge clk);
    bus.mem_resp_v_i    = 1'b1;
    bus.mem_resp_data_i = D_LATE;
    @(negedge clk);
    bus.mem_resp_v_i    = 1'b0;
    #1;
    checks++; if ({bus.ic_resp_v_o, bus.dc_resp_v_o} !== 2'b00) begin errors++; $display("FAIL stray idle resp_v: got %b%b expected 00", bus.ic_resp_v_o, bus.dc_resp_v_o); end
    checks++; if (bus.mem_req_v_o !== 1'b0) begin errors++; $display("FAIL stray idle mem_req_v: got %b expected 0", bus.mem_req_v_o); end
    bus.ic_req_v_i = 1'b1;
    bus.ic_addr_i  = 32'h0000_0500;
    #1;
    checks++; if (bus.ic_req_ready_o !== 1'b1) begin errors++; $display("FAIL stray still idle: got %b expected 1", bus.ic_req_ready_o); end
    @(negedge clk);
    bus.ic_req_v_i   = 1'b0;
    bus.mem_resp_v_i = 1'b1;
    @(negedge clk);
    bus.mem_resp_v_i = 1'b0;
    #1;
    checks++; if ({bus.ic_resp_v_o, bus.dc_resp_v_o} !== 2'b00) begin errors++; $display("FAIL stray issue resp_v: got %b%b expected 00", bus.ic_resp_v_o, bus.dc_resp_v_o); end
    checks++; if (bus.mem_req_v_o !== 1'b1) begin errors++; $display("FAIL stray issue mem_req_v: got %b expected 1", bus.mem_req_v_o); end
    bus.mem_req_ready_i = 1'b1;
    @(negedge clk);
    bus.mem_req_ready_i = 1'b0;
    bus.mem_resp_v_i    = 1'b1;
    bus.mem_resp_data_i = D_IC3;
    @(negedge clk);
    bus.mem_resp_v_i    = 1'b0;
    #1;
    checks++; if (bus.ic_resp_v_o !== 1'b1) begin errors++; $display("FAIL stray then ic_resp_v: got %b expected 1", bus.ic_resp_v_o); end
    checks++; if (bus.ic_resp_data_o !== D_IC3) begin errors++; $display("FAIL stray then ic_resp_data: got %h expected %h", bus.ic_resp_data_o, D_IC3); end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    bus.ic_req_v_i = 1'b1;
    bus.ic_addr_i  = 32'h0000_0600;
    @(negedge clk);
    bus.ic_req_v_i      = 1'b0;
    bus.mem_req_ready_i = 1'b1;
    @(negedge clk);
    bus.mem_req_ready_i = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.ic_resp_data_o !== 128'h0) begin errors++; $display("FAIL rstmid ic_resp_data: got %h expected 0", bus.ic_resp_data_o); end
    checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL rstmid mem_addr: got %h expected 0", bus.mem_addr_o); end
    checks++; if (bus.mem_req_v_o !== 1'b0) begin errors++; $display("FAIL rstmid mem_req_v: got %b expected 0", bus.mem_req_v_o); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_resp_v_i    = 1'b1;
    bus.mem_resp_data_i = D_LATE;
    @(negedge clk);
    bus.mem_resp_v_i    = 1'b0;
    #1;
    checks++; if ({bus.ic_resp_v_o, bus.dc_resp_v_o} !== 2'b00) begin errors++; $display("FAIL rstmid late resp_v: got %b%b expected 00", bus.ic_resp_v_o, bus.dc_resp_v_o); end
    bus.ic_req_v_i = 1'b1;
    bus.ic_addr_i  = 32'h0000_070C;
    #1;
    checks++; if (bus.ic_req_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid next ic_ready: got %b expected 1", bus.ic_req_ready_o); end
    @(negedge clk);
    bus.ic_req_v_i      = 1'b0;
    bus.mem_req_ready_i = 1'b1;
    #1;
    checks++; if (bus.mem_addr_o !== 32'h0000_0700) begin errors++; $display("FAIL rstmid next mem_addr: got %h expected 00000700", bus.mem_addr_o); end
    @(negedge clk);
    bus.mem_req_ready_i = 1'b0;
    bus.mem_resp_v_i    = 1'b1;
    bus.mem_resp_data_i = D_IC4;
    @(negedge clk);
    bus.mem_resp_v_i    = 1'b0;
    #1;
    checks++; if (bus.ic_resp_v_o !== 1'b1) begin errors++; $display("FAIL rstmid next ic_resp_v: got %b expected 1", bus.ic_resp_v_o); end
    checks++; if (bus.ic_resp_data_o !== D_IC4) begin errors++; $display("FAIL rstmid next ic_resp_data: got %h expected %h", bus.ic_resp_data_o, D_IC4); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    clear_inputs();
    test_reset();
    test_ic_read();
    test_back_to_back();
    test_dc_write_backpressure();
    test_contention();
    test_stray_response();
    test_reset_mid_op();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rvga_mem_arbiter.md
# rvga_mem_arbiter

Two-port memory arbiter sharing the single cacheline-wide backing-memory port between the instruction-fetch cache (IC) and the data cache (DC). It accepts one request at a time, sends it to memory with a valid/ready handshake, and holds ownership until memory responds. It then returns the response to the owning requester and re-arbitrates round-robin. It sits between the two L1 caches and the memory model or controller.

## Interface
- `ADDR_W`, default 32, byte address width (`rvga_word`).
- `LINE_W`, default 128, line width (`rvga_cacheline`); `MASK_W = LINE_W/8`.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low (one clock domain).
- `ic_req_v_i`  in  1  IC read request valid.
- `ic_addr_i`  in  `ADDR_W`  IC line address.
- `ic_req_ready_o`  out  1  IC request accepted this cycle.
- `ic_resp_v_o`  out  1  IC response valid, one-cycle pulse.
- `ic_resp_data_o`  out  `LINE_W`  IC fill line.
- `dc_req_v_i`  in  1  DC request valid.
- `dc_we_i`  in  1  1 = line write, 0 = read.
- `dc_addr_i`  in  `ADDR_W`  DC line address.
- `dc_wdata_i`  in  `LINE_W`  write data.
- `dc_wmask_i`  in  `MASK_W`  byte enables.
- `dc_req_ready_o`  out  1  DC request accepted.
- `dc_resp_v_o`  out  1  DC response or write ack, one-cycle pulse.
- `dc_resp_data_o`  out  `LINE_W`  DC read line.
- `mem_req_v_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `mem_wmask_o`  out  1/1/`ADDR_W`/`LINE_W`/`MASK_W`  memory request.
- `mem_req_ready_i`  in  1  memory accepts request.
- `mem_resp_v_i`  in  1  memory response valid (reads and writes).
- `mem_resp_data_i`  in  `LINE_W`  read data.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT. Reset state is IDLE.
- **IDLE, arbitration:**
  - Only one requester valid: grant it.
  - Both valid: grant the one not in `last_grant`.
  - `last_grant` resets to DC, so the first tie goes to IC.
  - `*_req_ready_o` is asserted combinationally to the granted requester only; never to both, never outside IDLE.
- **Accept** (`v & ready`): latch owner, we, addr, wdata and wmask; update `last_grant`; go to ISSUE.
  - IC requests latch `we = 0`, `wmask = 0`, `wdata = 0`.
- **ISSUE:** `mem_req_v_o = 1` with the latched fields held stable. When `mem_req_ready_i` is seen, go to WAIT.
- **WAIT:** when `mem_resp_v_i` is seen:
  - Register `mem_resp_data_i` into the owner's `resp_data`.
  - Pulse the owner's `resp_v` on the next cycle.
  - Go to IDLE.
  - A write ack returns DC data as all zeros.
- **Address alignment:** `mem_addr_o` is the latched address with bits [$clog2(MASK_W)-1:0] forced to zero.
- **Ignored inputs:** `mem_resp_v_i` in IDLE or ISSUE. `mem_req_ready_i` outside ISSUE.
- **Response data hold:** `*_resp_data_o` holds its value until the next response to that requester.
- **Reset mid-operation:** the FSM returns to IDLE asynchronously and the latched request is discarded. No response is delivered for it.

## Timing
- **Reset values:** all `*_ready_o`, `*_resp_v_o`, `mem_req_v_o`, `mem_we_o` = 0. All data, address and mask outputs = 0.
- **Cycle sequence:**
  - Accept at cycle N.
  - `mem_req_v_o` high from N+1.
  - Memory accepts at cycle A ≥ N+1.
  - Memory responds at R ≥ A+1; a response in the same cycle as acceptance is illegal.
  - `resp_v_o` pulses at R+1, with the FSM in IDLE at R+1.
- **Back-to-back:** a new request can be accepted at R+1, in the same cycle as the previous `resp_v_o`.
- **Minimum round trip:** accept to `resp_v` is 3 cycles.
- **Requester rule:** a requester keeps `req_v` and its fields stable until it sees ready. The arbiter does not latch fields in any cycle without ready.
- **Fairness:** under continuous contention, grants alternate IC, DC, IC, … Neither side waits more than one foreign transaction.

## Structure
- **Additions to the shared rvga_types package:**
  - `rvga_mem_owner_e` {`e_rvga_owner_ic`, `e_rvga_owner_dc`}
  - `rvga_arb_state_e` {`e_rvga_arb_idle`, `e_rvga_arb_issue`, `e_rvga_arb_wait`}
  - `typedef logic[15:0] rvga_bytemask`
  - `parameter LINE_BYTES = 16`
- **Sub-module:** `rvga_rr_arb2`, a combinational two-way round-robin picker (`req[1:0]`, `last`, `gnt[1:0]`), reused later for the register-file write port. The FSM and request/response registers stay in `rvga_mem_arbiter`.

## Test plan
- **IC read alone:** IC read `0x0000_1234`; `mem_req_ready_i` at N+1, `mem_resp_v_i` at N+2 with data `0xDEAD…BEEF` → `mem_addr_o = 0x0000_1230`, `we = 0`; `ic_resp_v_o` pulses at N+3 with that data; `dc_resp_v_o` stays 0.
- **Simultaneous first requests:** IC `0x100` and DC `0x200` in the same cycle after reset → IC granted first; DC ready only after the IC response; DC transaction uses `mem_addr_o = 0x200`.
- **DC write with memory backpressure:** DC write `addr 0x40`, `wmask 0x00F0`, `mem_req_ready_i` low for 5 cycles → request fields stable through all 6 ISSUE cycles; `dc_resp_v_o` pulses with data 0 one cycle after the ack.
- **Continuous contention:** both requesters valid for 6 transactions → grant order IC, DC, IC, DC, IC, DC.
- **Stray response:** `mem_resp_v_i` asserted in IDLE and in ISSUE → no `resp_v` on either port; FSM state unchanged.
- **Reset mid-operation:** `rst_n` asserted while in WAIT → outputs zero immediately; after release, a late `mem_resp_v_i` produces no response; next IC request completes normally.
